screen_reader: RTL

//   Scans the screen memory map word by word and emits a serial pixel stream for the display.

---
 rtl/screen_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/screen_reader.sv
// Screen memory read side: fetches one word per read, then shifts its pixels
// out LSB-first under a valid/ready handshake, word after word, one frame per start.
module screen_reader #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned ADDR_WIDTH    = 13,
  parameter int unsigned WORDS_PER_ROW = 32,
  parameter int unsigned ROWS          = 256,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [WIDTH-1:0]      rd_data_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic                  pix_o,
  output logic                  sol_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LW = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS_PER_ROW * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_WORDS = ADDR_WIDTH'(WORDS_PER_ROW);
  localparam logic [CW-1:0]         LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [LW-1:0]         LAT_DONE  = LW'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0]      shift, shift_n;
  logic [LW-1:0]         lat, lat_n;
  logic                  rd_en_n, pix_valid_n, pix_n, sol_n, eof_n, busy_n, done_n;
  logic                  xfer;

  assign xfer      = pix_valid_o & pix_ready_i;
  assign rd_addr_o = addr;

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      addr        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      lat         <= '0;
      rd_en_o     <= 1'b0;
      pix_valid_o <= 1'b0;
      pix_o       <= 1'b0;
      sol_o       <= 1'b0;
      eof_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      lat         <= lat_n;
      rd_en_o     <= rd_en_n;
      pix_valid_o <= pix_valid_n;
      pix_o       <= pix_n;
      sol_o       <= sol_n;
      eof_o       <= eof_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
    end
  end

  // Next state/datapath; outputs are decoded from the next values so they register in step
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    lat_n       = lat;
    rd_en_n     = 1'b0;
    pix_valid_n = 1'b0;
    pix_n       = 1'b0;
    sol_n       = 1'b0;
    eof_n       = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_FETCH;
          addr_n  = '0;
        end
      end
      S_FETCH: begin
        state_n = S_WAIT;
        lat_n   = LW'(1);
      end
      S_WAIT: begin
        if (lat == LAT_DONE) begin
          shift_n   = rd_data_i;
          bit_cnt_n = '0;
          state_n   = S_SHIFT;
        end else begin
          lat_n = lat + LW'(1);
        end
      end
      S_SHIFT: begin
        if (xfer) begin
          shift_n   = shift >> 1;
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            if (addr == LAST_WORD) begin
              state_n = S_DONE;
            end else begin
              addr_n  = addr + ADDR_WIDTH'(1);
              state_n = S_FETCH;
            end
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort wins over everything; an in-flight read is simply never sampled
    if (abort_i && (state != S_IDLE)) begin
      state_n = S_IDLE;
    end

    rd_en_n     = (state_n == S_FETCH);
    pix_valid_n = (state_n == S_SHIFT);
    pix_n       = (state_n == S_SHIFT) && shift_n[0];
    sol_n       = (state_n == S_SHIFT) && ((addr_n % ROW_WORDS) == '0) && (bit_cnt_n == '0);
    eof_n       = (state_n == S_SHIFT) && (addr_n == LAST_WORD) && (bit_cnt_n == LAST_BIT);
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
  end

endmodule
